// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operand loader, the 8-bit ALU behind it and
// their benches.
//   state_t      : loader sequencer states, ST_WAIT_A .. ST_SEND
//   OP_*         : 6-bit ALU opcode constants (low six bits of the opcode byte)
//   is_busy_state: true in the states where an incoming byte cannot be taken
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_LATCH   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_SEND    = 3'd5
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    function automatic logic is_busy_state(input state_t s);
        return (s == ST_LATCH) || (s == ST_CAPTURE) || (s == ST_SEND);
    endfunction

endpackage

// File: rtl/alu_operand_loader_timer.sv
// -----------------------------------------------------------------------------
// inter_byte_timer
// Counts clock cycles while enabled; flags expiry when the count has reached
// TIMEOUT_CYCLES-1. Only built when ALU_LOADER_TIMEOUT_EN is defined.
// Ports:
//   clk     in  system clock
//   rst_n   in  synchronous active-low reset (count <= 0)
//   clear   in  force count to 0 (has priority over counting)
//   enable  in  count this cycle
//   expire  out combinational: enable and count at terminal value
// -----------------------------------------------------------------------------
module inter_byte_timer #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    assign expire = enable && (r_count == TERMINAL);

    // Holding at the terminal value keeps the counter from wrapping if the
    // owner is slow to clear it after expiry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expire) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/alu_operand_loader.sv
// -----------------------------------------------------------------------------
// alu_operand_loader
// Sequencer between the UART receiver and the 8-bit ALU. Takes three bytes
// (operand A, operand B, opcode), loads them into the ALU via entrada and the
// b1/b2/b3 strobes, captures the ALU result and hands it to the transmitter.
//
// Optional feature macro: ALU_LOADER_TIMEOUT_EN
//   defined   : a partial frame is abandoned after TIMEOUT_CYCLES idle cycles
//               in WAIT_B/WAIT_OP, signalled by a one-cycle timeout pulse
//   undefined : no timer, timeout is always 0, a partial frame waits forever
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   rx_data   in   received byte, qualified by rx_valid
//   rx_valid  in   one-cycle strobe per received byte
//   result    in   combinational ALU result
//   entrada   out  registered data bus to the ALU
//   b1/b2/b3  out  one-cycle load strobes for operand A / operand B / opcode
//   tx_ready  in   transmitter idle
//   tx_data   out  captured ALU result
//   tx_start  out  one-cycle send strobe
//   overrun   out  sticky: a byte arrived while a frame was being processed
//   timeout   out  one-cycle pulse on inter-byte timeout
//
// State table:
//   ST_WAIT_A  | waiting for operand A byte
//   ST_WAIT_B  | waiting for operand B byte
//   ST_WAIT_OP | waiting for opcode byte
//   ST_LATCH   | b3 high; ALU registers the opcode at the end of this cycle
//   ST_CAPTURE | ALU inputs stable; register result into tx_data
//   ST_SEND    | wait for tx_ready, then pulse tx_start
// -----------------------------------------------------------------------------
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int DATA_SIZE      = 8,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_SIZE-1:0] rx_data,
    input  logic                 rx_valid,
    input  logic [DATA_SIZE-1:0] result,
    output logic [DATA_SIZE-1:0] entrada,
    output logic                 b1,
    output logic                 b2,
    output logic                 b3,
    input  logic                 tx_ready,
    output logic [DATA_SIZE-1:0] tx_data,
    output logic                 tx_start,
    output logic                 overrun,
    output logic                 timeout
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("alu_operand_loader: TIMEOUT_CYCLES must be at least 2");
    end

    state_t               r_state;
    logic [DATA_SIZE-1:0] r_entrada;
    logic [DATA_SIZE-1:0] r_tx_data;
    logic                 r_b1;
    logic                 r_b2;
    logic                 r_b3;
    logic                 r_tx_start;
    logic                 r_overrun;
    logic                 r_timeout;
    logic                 w_expire;

`ifdef ALU_LOADER_TIMEOUT_EN
    logic w_timer_en;
    logic w_timer_clear;

    // The timer only runs while a frame is partially received. Any byte
    // (accepted or not) restarts it; leaving the waiting states resets it, so
    // WAIT_A always starts a fresh count.
    assign w_timer_en    = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
    assign w_timer_clear = rx_valid || !w_timer_en;

    inter_byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_timer_clear),
        .enable (w_timer_en),
        .expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_WAIT_A;
            r_entrada  <= '0;
            r_tx_data  <= '0;
            r_b1       <= 1'b0;
            r_b2       <= 1'b0;
            r_b3       <= 1'b0;
            r_tx_start <= 1'b0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_b1       <= 1'b0;
            r_b2       <= 1'b0;
            r_b3       <= 1'b0;
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;

            case (r_state)
                ST_WAIT_A: begin
                    if (rx_valid) begin
                        r_entrada <= rx_data;
                        r_b1      <= 1'b1;
                        r_state   <= ST_WAIT_B;
                    end
                end
                // A byte in the expiry cycle wins over the timeout.
                ST_WAIT_B: begin
                    if (rx_valid) begin
                        r_entrada <= rx_data;
                        r_b2      <= 1'b1;
                        r_state   <= ST_WAIT_OP;
                    end else if (w_expire) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_WAIT_A;
                    end
                end
                ST_WAIT_OP: begin
                    if (rx_valid) begin
                        r_entrada <= rx_data;
                        r_b3      <= 1'b1;
                        r_state   <= ST_LATCH;
                    end else if (w_expire) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_WAIT_A;
                    end
                end
                // b3 is high during this state; the result is not yet valid.
                ST_LATCH: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_tx_data <= result;
                    r_state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        r_tx_start <= 1'b1;
                        r_state    <= ST_WAIT_A;
                    end
                end
                default: begin
                    r_state <= ST_WAIT_A;
                end
            endcase

            // Bytes arriving while a frame is in flight are lost, including
            // the one coinciding with the SEND->WAIT_A transition.
            if (rx_valid && is_busy_state(r_state)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign entrada  = r_entrada;
    assign b1       = r_b1;
    assign b2       = r_b2;
    assign b3       = r_b3;
    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign overrun  = r_overrun;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_alu_operand_loader.sv
module tb_alu_operand_loader;
    import alu_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] alu_result;
    logic [7:0] entrada;
    logic [7:0] tx_data;
    logic       b1, b2, b3, tx_start, overrun, timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_operand_loader #(
        .DATA_SIZE(8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .result   (alu_result),
        .entrada  (entrada),
        .b1       (b1),
        .b2       (b2),
        .b3       (b3),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .overrun  (overrun),
        .timeout  (timeout)
    );

    // Reference arithmetic of the ALU, straight from the opcode table.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRA:  return 8'($signed(a) >>> b);
            OP_SRL:  return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    // ALU behind the loader: registers its inputs on the load strobes.
    logic [7:0] alu_a = 8'h00;
    logic [7:0] alu_b = 8'h00;
    logic [5:0] alu_op = 6'h00;
    always @(posedge clk) begin
        if (b1) alu_a <= entrada;
        if (b2) alu_b <= entrada;
        if (b3) alu_op <= entrada[5:0];
    end
    assign alu_result = alu_ref(alu_a, alu_b, alu_op);

    // Event monitor, sampled on the falling edge.
    int n_b1 = 0, n_b2 = 0, n_b3 = 0, n_start = 0, n_multi = 0, n_timeout = 0, n_bad_start = 0;
    logic [7:0] last_b1 = 8'h00, last_b2 = 8'h00, last_b3 = 8'h00;
    logic ready_at_edge = 1'b0;
    always @(posedge clk) ready_at_edge <= tx_ready;
    always @(negedge clk) begin
        if (b1) begin n_b1++; last_b1 = entrada; end
        if (b2) begin n_b2++; last_b2 = entrada; end
        if (b3) begin n_b3++; last_b3 = entrada; end
        if ($countones({b1, b2, b3}) > 1) n_multi++;
        if (tx_start) begin
            n_start++;
            if (!ready_at_edge) n_bad_start++;
        end
        if (timeout) n_timeout++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Sends a frame, waits for the result handoff and checks it.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input logic [7:0] exp, input int hold, input bit extra,
                             input string nm);
        int s0 = n_start;
        int c1 = n_b1;
        int c2 = n_b2;
        int c3 = n_b3;
        tx_ready = (hold == 0);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        if (extra) send_byte(8'hAA);
        if (hold > 0) begin
            tick(hold);
            tx_ready = 1'b1;
        end
        for (int k = 0; k < 20 && n_start == s0; k++) tick();
        tick(2);
        checks++;
        if (n_start - s0 != 1)
            begin errors++; $display("FAIL %s tx_start count got %0d want 1", nm, n_start - s0); end
        checks++;
        if (tx_data !== exp)
            begin errors++; $display("FAIL %s tx_data got %02h want %02h", nm, tx_data, exp); end
        checks++;
        if (n_b1 - c1 != 1 || n_b2 - c2 != 1 || n_b3 - c3 != 1 ||
            last_b1 !== a || last_b2 !== b || last_b3 !== op)
            begin
                errors++;
                $display("FAIL %s strobes got b1=%0d/%02h b2=%0d/%02h b3=%0d/%02h want 1/%02h 1/%02h 1/%02h",
                         nm, n_b1 - c1, last_b1, n_b2 - c2, last_b2, n_b3 - c3, last_b3, a, b, op);
            end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++;
        if ({entrada, tx_data, b1, b2, b3, tx_start, overrun, timeout} !== 22'h0)
            begin
                errors++;
                $display("FAIL reset outputs got entrada=%02h tx_data=%02h b=%b%b%b start=%b ovr=%b to=%b want all 0",
                         entrada, tx_data, b1, b2, b3, tx_start, overrun, timeout);
            end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        run_frame(8'h05, 8'h03, 8'h20, 8'h08, 0, 1'b0, "add");
    endtask

    task automatic test_shifts();
        run_frame(8'h80, 8'h02, 8'h03, 8'hE0, 0, 1'b0, "sra");
        run_frame(8'h80, 8'h02, 8'h02, 8'h20, 0, 1'b0, "srl");
    endtask

    task automatic test_backpressure();
        int s0 = n_start;
        int early = 0;
        int bad_data = 0;
        tx_ready = 1'b0;
        send_byte(8'h0F);
        send_byte(8'hF0);
        send_byte(8'h25);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (n_start != s0) early++;
            if (k >= 3 && tx_data !== 8'hFF) bad_data++;
        end
        checks++;
        if (early != 0)
            begin errors++; $display("FAIL bp_holdoff tx_start seen %0d cycles want 0", early); end
        checks++;
        if (bad_data != 0 || tx_data !== 8'hFF)
            begin errors++; $display("FAIL bp_data tx_data got %02h (%0d bad) want ff", tx_data, bad_data); end
        tx_ready = 1'b1;
        tick();
        checks++;
        if (tx_start !== 1'b1)
            begin errors++; $display("FAIL bp_fire tx_start got %b want 1", tx_start); end
        tick(3);
        checks++;
        if (n_start - s0 != 1)
            begin errors++; $display("FAIL bp_once tx_start count got %0d want 1", n_start - s0); end
    endtask

    task automatic test_overrun();
        checks++;
        if (overrun !== 1'b0)
            begin errors++; $display("FAIL ovr_pre overrun got %b want 0", overrun); end
        run_frame(8'h09, 8'h04, 8'h22, 8'h05, 0, 1'b1, "ovr_frame");
        checks++;
        if (overrun !== 1'b1)
            begin errors++; $display("FAIL ovr_set overrun got %b want 1", overrun); end
        run_frame(8'h33, 8'h0F, 8'h24, 8'h03, 0, 1'b0, "ovr_next");
        checks++;
        if (overrun !== 1'b1)
            begin errors++; $display("FAIL ovr_sticky overrun got %b want 1", overrun); end
    endtask

    task automatic test_midframe_reset();
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        tick();
        checks++;
        if ({entrada, tx_data, b1, b2, b3, tx_start, overrun, timeout} !== 22'h0)
            begin
                errors++;
                $display("FAIL midreset outputs got entrada=%02h tx_data=%02h b=%b%b%b start=%b ovr=%b to=%b want all 0",
                         entrada, tx_data, b1, b2, b3, tx_start, overrun, timeout);
            end
        rst_n = 1'b1;
        tick();
        run_frame(8'h01, 8'h01, 8'h22, 8'h00, 0, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        logic [5:0] ops [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
        for (int i = 0; i < 16; i++) begin
            logic [7:0] a, b, op;
            a = 8'($urandom);
            b = (i % 3 == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            op = (i % 5 == 4) ? 8'($urandom) : {2'b00, ops[$urandom_range(0, 7)]};
            run_frame(a, b, op, alu_ref(a, b, op[5:0]), $urandom_range(0, 4), 1'b0, "random");
        end
        checks++;
        if (overrun !== 1'b0)
            begin errors++; $display("FAIL rand_overrun overrun got %b want 0", overrun); end
    endtask

    // A byte landing in the same cycle that SEND hands off is dropped.
    task automatic test_back_to_back();
        int c1 = n_b1;
        int s0 = n_start;
        tx_ready = 1'b0;
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h26);
        tick(4);
        tx_ready = 1'b1;
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick(3);
        checks++;
        if (n_start - s0 != 1 || tx_data !== 8'h01)
            begin errors++; $display("FAIL b2b_send count=%0d tx_data=%02h want 1 01", n_start - s0, tx_data); end
        checks++;
        if (n_b1 - c1 != 1 || overrun !== 1'b1)
            begin errors++; $display("FAIL b2b_drop b1 count=%0d overrun=%b want 1 1", n_b1 - c1, overrun); end
        run_frame(8'h10, 8'h20, 8'h20, 8'h30, 0, 1'b0, "b2b_next");
    endtask

    task automatic test_timeout();
`ifdef ALU_LOADER_TIMEOUT_EN
        int t0 = n_timeout;
        int c2 = n_b2;
        int first = -1;
        send_byte(8'h12);
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (timeout && first < 0) first = k;
        end
        checks++;
        if (first != TO)
            begin errors++; $display("FAIL to_cycle timeout at %0d want %0d", first, TO); end
        checks++;
        if (n_timeout - t0 != 1 || n_b2 != c2)
            begin errors++; $display("FAIL to_pulse pulses=%0d b2=%0d want 1 0", n_timeout - t0, n_b2 - c2); end
        run_frame(8'h07, 8'h02, 8'h22, 8'h05, 0, 1'b0, "to_fresh");
`else
        send_byte(8'h12);
        tick(3 * TO);
        send_byte(8'h03);
        send_byte(8'h20);
        tick(4);
        checks++;
        if (n_timeout != 0 || tx_data !== 8'h15)
            begin errors++; $display("FAIL no_timeout pulses=%0d tx_data=%02h want 0 15", n_timeout, tx_data); end
`endif
    endtask

    task automatic test_invariants();
        checks++;
        if (n_multi != 0)
            begin errors++; $display("FAIL strobe_excl overlapping strobes %0d want 0", n_multi); end
        checks++;
        if (n_bad_start != 0)
            begin errors++; $display("FAIL start_ready tx_start without ready %0d want 0", n_bad_start); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shifts();
        test_backpressure();
        test_overrun();
        test_midframe_reset();
        test_random();
        test_back_to_back();
        test_timeout();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
